// File: rtl/mole_spawner.sv
// Purpose : picks when the next target LED lights and which one, then issues a
//           one-cycle led_request with led_index to the LED timer controller.
// Latency : first request interval(level)+1 cycles after enable is sampled;
//           period interval(level)+2 while the first pick succeeds.
// Backpres: led_busy vetoes busy candidates; MAX_TRIES busy picks in a row
//           drop the spawn (drop_count) instead of stalling.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   enable              spawning allowed while high
//   level[1:0]          difficulty; 2'b11 behaves as 2'b10
//   led_busy[NUM_LEDS]  bit i high = LED i currently lit
//   led_index[4:0]      requested LED, meaningful with led_request
//   led_request         single-cycle request pulse
//   spawn_count[7:0]    successful requests, saturating at 255
//   drop_count[7:0]     dropped spawns, saturating at 255
//
// Optional build macro SPAWN_JITTER_EN: when defined, each reload subtracts
// lfsr[2:0]*(interval>>4) so the spawn period varies between ~56% and 100%.

module mole_spawner #(
  parameter int          NUM_LEDS    = 18,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned INTERVAL_L0 = 50000000,
  parameter int unsigned INTERVAL_L1 = 25000000,
  parameter int unsigned INTERVAL_L2 = 12500000,
  parameter int          MAX_TRIES   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [1:0]          level,
  input  logic [NUM_LEDS-1:0] led_busy,
  output logic [4:0]          led_index,
  output logic                led_request,
  output logic [7:0]          spawn_count,
  output logic [7:0]          drop_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_PICK  = 2'd2;
  localparam logic [1:0] S_ISSUE = 2'd3;

  localparam int         TW  = $clog2(MAX_TRIES + 1);
  localparam logic [5:0] NL6 = 6'(NUM_LEDS);

  logic [1:0]    state;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_next;
  logic [31:0]   cnt;
  logic [TW-1:0] tries;
  logic [31:0]   interval;
  logic [31:0]   reload;
  logic [4:0]    cand;
  logic [31:0]   busy_ext;

  // Galois LFSR, x^16+x^14+x^13+x^11+1, shifting right
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    case (level)
      2'b00:   interval = 32'(INTERVAL_L0);
      2'b01:   interval = 32'(INTERVAL_L1);
      default: interval = 32'(INTERVAL_L2);
    endcase
`ifdef SPAWN_JITTER_EN
    reload = interval - 32'd1 - (32'(lfsr[2:0]) * (interval >> 4));
`else
    reload = interval - 32'd1;
`endif
  end

  // Fold the 5-bit random value into 0..NUM_LEDS-1 with a single subtract;
  // exact for NUM_LEDS >= 16.
  always_comb begin
    if ({1'b0, lfsr[4:0]} >= NL6) cand = lfsr[4:0] - NL6[4:0];
    else                          cand = lfsr[4:0];
  end

  // Zero-extend so any 5-bit candidate is a legal index
  always_comb begin
    busy_ext = '0;
    busy_ext[NUM_LEDS-1:0] = led_busy;
  end

  assign led_request = (state == S_ISSUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      lfsr        <= LFSR_SEED;
      cnt         <= '0;
      tries       <= '0;
      led_index   <= '0;
      spawn_count <= '0;
      drop_count  <= '0;
    end else begin
      lfsr <= lfsr_next;
      case (state)
        S_IDLE: begin
          if (enable) begin
            cnt   <= reload;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (cnt == 32'd0) begin
            tries <= '0;
            state <= S_PICK;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_PICK: begin
          // tries counts busy candidates seen; the drop is taken on the cycle
          // after the MAX_TRIES-th busy candidate.
          if (!enable) begin
            state <= S_IDLE;
          end else if (tries == TW'(MAX_TRIES)) begin
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            cnt   <= reload;
            state <= S_WAIT;
          end else if (!busy_ext[cand]) begin
            led_index <= cand;
            state     <= S_ISSUE;
          end else begin
            tries <= tries + 1'b1;
          end
        end
        S_ISSUE: begin
          // The pulse always completes; enable only decides where we go next
          if (spawn_count != 8'hFF) spawn_count <= spawn_count + 8'd1;
          if (enable) begin
            cnt   <= reload;
            state <= S_WAIT;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mole_spawner.md
Name: mole_spawner

Overview:
- Initiator side of the led_index/led_request interface into the LED timer controller: decides when a new target LED lights and which one.
- Pseudo-random index from an LFSR, spawn interval set by difficulty level; never requests an LED that is already lit (led_busy feedback from the LED controller).
- Sits between the difficulty register and the LED controller; also reports spawn statistics for the score/debug displays.

Parameters:
- NUM_LEDS, 18, number of target LEDs; legal indices 0..NUM_LEDS-1 (max 32)
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero
- INTERVAL_L0, 50000000, clk cycles between spawns at level 0 (1 s at 50 MHz)
- INTERVAL_L1, 25000000, cycles between spawns at level 1
- INTERVAL_L2, 12500000, cycles between spawns at level 2 and level 3
- MAX_TRIES, 8, pick attempts per spawn before the spawn is dropped

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  spawning allowed while high
- level  in  2  difficulty; 2'b11 treated as 2'b10
- led_busy  in  NUM_LEDS  bit i high = LED i currently lit
- led_index  out  5  index of requested LED; valid only with led_request
- led_request  out  1  single-cycle request pulse
- spawn_count  out  8  successful requests since reset, saturates at 255
- drop_count  out  8  dropped spawns since reset, saturates at 255

Behaviour:
- Reset (async): FSM=IDLE, led_index=0, led_request=0, spawn_count=0, drop_count=0, LFSR=LFSR_SEED, interval counter=0, try counter=0.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1; advances every clk cycle regardless of state.
- Index mapping: cand = lfsr[4:0]; if cand >= NUM_LEDS then cand = cand - NUM_LEDS (width 5, no wrap for NUM_LEDS >= 16).
- States:
  - IDLE: led_request=0. enable=1 -> load counter with interval(level)-1, go WAIT.
  - WAIT: counter decrements each cycle; at 0 -> try counter=0, go PICK. enable=0 -> IDLE.
  - PICK: one candidate per cycle. led_busy[cand]=0 -> register led_index=cand, go ISSUE. Busy -> try counter+1; after MAX_TRIES busy candidates, drop_count+1 (saturating), reload counter, go WAIT. enable=0 -> IDLE, no request.
  - ISSUE: led_request=1 for exactly this cycle, spawn_count+1 (saturating), reload counter with interval(level)-1, go WAIT.
- Latency: first request no earlier than interval(level)+1 cycles after enable rises; steady-state period = interval+2 cycles when the first pick succeeds.
- Level change: sampled only at each counter reload; a change mid-WAIT takes effect on the next interval.
- All LEDs busy: every pick fails -> drop after MAX_TRIES cycles, no request.
- enable falling during ISSUE: pulse still completes; FSM then goes to IDLE.
- led_request never high on two consecutive cycles; led_index holds its value between requests.
- Reset mid-operation: outputs clear immediately; an in-progress request pulse is cut.

Optional Feature:
- Macro SPAWN_JITTER_EN.
- Defined: reload value = interval(level)-1 - lfsr[2:0]*(interval(level)>>4); spawn period varies pseudo-randomly between ~56% and 100% of nominal.
- Undefined: reload value always interval(level)-1; fixed period. All other behaviour identical.

Test Plan:
- Simulate with INTERVAL_L0=16, L1=8, L2=4, SPAWN_JITTER_EN undefined.
- Reset, enable=1, level=0, led_busy=0 -> first led_request at cycle 18 after enable, then every 18 cycles; led_index < 18; spawn_count increments by 1 per pulse.
- level switched 0->2 mid-WAIT -> current period stays 18 cycles, following periods 6 cycles; level=3 gives the same 6-cycle period.
- led_busy=18'h3FFFF -> no led_request ever; drop_count increments once per 16+1+8 cycles; spawn_count stays 0.
- led_busy all ones except bit 5 -> every led_request carries led_index=5 or the spawn is dropped; never any other index.
- enable dropped during WAIT and during PICK -> no pulse; FSM in IDLE; re-enable restarts the full interval.
- Assert rst mid-WAIT, then 300 requests with spawn_count checked -> counters clear to 0 asynchronously; spawn_count saturates at 255.
